// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//   Bimodal / gshare branch predictor: ENTRIES saturating counters of
//   CTR_BITS each, plus the branch target adder used in ID.
//
//   Lookup (ID, combinational):
//     lookup_valid_i, lookup_pc_i, lookup_offset_i -> predict_o, target_o,
//     lookup_idx_o (the CPU carries lookup_idx_o down to MA).
//   Update (MA, registered):
//     update_valid_i, update_idx_i, update_taken_i, update_mispred_i.
//   Status:
//     ready_o          low while the table is being swept after reset.
//     stat_branches_o  resolved conditional branches (saturating).
//     stat_mispred_o   mispredicted branches (saturating).
//   clk_i / reset_i: rising-edge clock, synchronous active-high reset.
//
//   The table has no reset of its own: after reset an INIT sweep writes the
//   weakly-not-taken value into every entry, one per cycle, and ready_o
//   rises once the last entry is written.
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int GSHARE   = 0,
  parameter int GHR_BITS = 6,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic             ready_o,
  // lookup (ID)
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  input  logic [31:0]      lookup_offset_i,
  output logic             predict_o,
  output logic [31:0]      target_o,
  output logic [IDX_W-1:0] lookup_idx_o,
  // training (MA)
  input  logic             update_valid_i,
  input  logic [IDX_W-1:0] update_idx_i,
  input  logic             update_taken_i,
  input  logic             update_mispred_i,
  // performance counters
  output logic [31:0]      stat_branches_o,
  output logic [31:0]      stat_mispred_o
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [IDX_W-1:0]    PTR_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q;
  logic                ready_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [31:0]         br_q, br_d;
  logic [31:0]         mp_q, mp_d;
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;
  logic [IDX_W-1:0]    pc_idx;
  logic                upd_en;

  // Training only counts once the sweep is done; updates during INIT are dropped.
  assign upd_en = (state_q == ST_RUN) & update_valid_i;

  // -------------------------------------------------------------------------
  // Init sweep / run FSM. ready_q is registered alongside the state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;

  // -------------------------------------------------------------------------
  // Counter table. Sweep writes and training writes are mutually exclusive
  // by state. A reset cycle writes nothing, so an update in flight is lost.
  // -------------------------------------------------------------------------
  assign ctr_cur = ctr_q[update_idx_i];

  always_comb begin
    ctr_d = ctr_cur;
    if (update_taken_i) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0)      ctr_d = ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == ST_INIT)  ctr_q[ptr_q]        <= CTR_WNT;
      else if (update_valid_i) ctr_q[update_idx_i] <= ctr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Index generation. Instruction-aligned PC bits, optionally hashed with
  // the resolved-branch history (history never updates speculatively).
  // -------------------------------------------------------------------------
  assign pc_idx = lookup_pc_i[IDX_W+1:2];

  generate
    if (GSHARE != 0) begin : g_gshare
      logic [GHR_BITS-1:0] ghr_q, ghr_d;

      always_comb begin
        ghr_d = ghr_q;
        // Shift left, new outcome in LSB; the cast drops the oldest bit.
        if (upd_en) ghr_d = GHR_BITS'({ghr_q, update_taken_i});
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) ghr_q <= '0;
        else         ghr_q <= ghr_d;
      end

      // Size cast zero-extends a short history or keeps the newest IDX_W bits.
      assign lookup_idx_o = pc_idx ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign lookup_idx_o = pc_idx;
    end
  endgenerate

  // Reads see the pre-update counter even when MA trains the same entry.
  assign predict_o = lookup_valid_i & ready_q & ctr_q[lookup_idx_o][CTR_BITS-1];
  assign target_o  = lookup_pc_i + lookup_offset_i;

  // -------------------------------------------------------------------------
  // Saturating performance counters.
  // -------------------------------------------------------------------------
  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (upd_en) begin
      if (br_q != '1)                      br_d = br_q + 32'd1;
      if (update_mispred_i && mp_q != '1)  mp_d = mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches_o = br_q;
  assign stat_mispred_o  = mp_q;

endmodule
